rj32_dbus: RTL

Data-bus responder for the rj32 CPU: the far end of the CPU's `A_data`/`D_out`/`w_en`/`D_in` port. It decodes each bus cycle into on-chip data RAM or one of four memory-mapped I/O registers, and returns registered read data. The I/O registers are LEDs, a UART transmit queue, UART status and a cycle counter. It sits in the top level beside the program and tile/map BRAMs and runs on the CPU clock.

---
 rtl/rj32_dbus_pkg.sv | 24 ++
 rtl/rj32_uart_tx.sv | 108 ++++++++++
 rtl/rj32_dbus.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rj32_dbus_pkg.sv
// Shared constants for the rj32 data-bus responder: I/O address map,
// UART transmitter states and UART status bit positions.
package rj32_dbus_pkg;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 16;

    localparam logic [ADDR_W-1:0] ADDR_LED       = 14'h3FFC;
    localparam logic [ADDR_W-1:0] ADDR_UART_DATA = 14'h3FFD;
    localparam logic [ADDR_W-1:0] ADDR_UART_STAT = 14'h3FFE;
    localparam logic [ADDR_W-1:0] ADDR_CYCLES    = 14'h3FFF;

    localparam int unsigned STAT_IDLE_BIT = 0;
    localparam int unsigned STAT_FULL_BIT = 1;
    localparam int unsigned STAT_OVF_BIT  = 2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/rj32_uart_tx.sv
// 8N1 UART transmitter with a per-bit divider; pulls bytes through a
// valid/ready pop interface, chaining frames without an idle gap.
module rj32_uart_tx
    import rj32_dbus_pkg::*;
#(
    parameter int unsigned CLK_DIV = 217
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready_c,
    output logic       o_idle_c,
    output logic       o_tx
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    uart_state_e      r_state, w_state_nxt;
    logic [DIV_W-1:0] r_div, w_div_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_tx, w_tx_nxt;
    logic             w_last;

    assign w_last   = (r_div == DIV_LAST);
    assign o_idle_c = (r_state == TX_IDLE);
    assign o_tx     = r_tx;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= TX_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // tx is registered: each branch sets the line level for the next bit
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div + DIV_W'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        o_ready_c   = 1'b0;
        case (r_state)
            TX_IDLE: begin
                o_ready_c = 1'b1;
                w_div_nxt = '0;
                w_tx_nxt  = 1'b1;
                if (i_valid) begin
                    w_state_nxt = TX_START;
                    w_shift_nxt = i_data;
                    w_tx_nxt    = 1'b0;
                end
            end
            TX_START: begin
                if (w_last) begin
                    w_state_nxt = TX_DATA;
                    w_div_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                end
            end
            TX_DATA: begin
                if (w_last) begin
                    w_div_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = TX_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_tx_nxt    = r_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (w_last) begin
                    o_ready_c = 1'b1;
                    w_div_nxt = '0;
                    if (i_valid) begin
                        w_state_nxt = TX_START;
                        w_shift_nxt = i_data;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = TX_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = TX_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rj32_dbus.sv
// rj32 data-bus responder: data RAM, LED, UART and cycle-counter registers.
// UART FIFO/transmitter/status exist only when RJ32_DBUS_UART_EN is defined.
module rj32_dbus
    import rj32_dbus_pkg::*;
#(
    parameter int unsigned RAM_AW     = 12,
    parameter int unsigned CLK_DIV    = 217,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] A_data,
    input  logic [DATA_W-1:0] D_out,
    input  logic              w_en,
    output logic [DATA_W-1:0] D_in,
    output logic [7:0]        leds,
    output logic              tx
);

    if (CLK_DIV < 2 || FIFO_DEPTH == 0 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("rj32_dbus: CLK_DIV must be >= 2 and FIFO_DEPTH a power of two");
    end

    logic [DATA_W-1:0] r_ram [0:(1 << RAM_AW) - 1];
    logic [DATA_W-1:0] r_d_in, r_cycles, w_rd_data, w_stat;
    logic [7:0]        r_leds;
    logic [RAM_AW-1:0] w_ram_addr;
    logic              w_is_ram, w_sel_led, w_sel_stat, w_sel_cyc;
    logic              w_stat_idle, w_stat_full, w_stat_ovf;

    assign w_ram_addr = A_data[RAM_AW-1:0];
    assign w_is_ram   = ~A_data[ADDR_W-1];
    assign w_sel_led  = (A_data == ADDR_LED);
    assign w_sel_stat = (A_data == ADDR_UART_STAT);
    assign w_sel_cyc  = (A_data == ADDR_CYCLES);

    assign D_in = r_d_in;
    assign leds = r_leds;

    // RAM storage is never reset
    always_ff @(posedge clock) begin
        if (w_en && w_is_ram) r_ram[w_ram_addr] <= D_out;
    end

    always_comb begin
        w_stat                = '0;
        w_stat[STAT_IDLE_BIT] = w_stat_idle;
        w_stat[STAT_FULL_BIT] = w_stat_full;
        w_stat[STAT_OVF_BIT]  = w_stat_ovf;
    end

    // Read mux samples pre-edge state, so same-cycle writes read first
    always_comb begin
        w_rd_data = '0;
        if (w_is_ram)        w_rd_data = r_ram[w_ram_addr];
        else if (w_sel_led)  w_rd_data = {8'h00, r_leds};
        else if (w_sel_stat) w_rd_data = w_stat;
        else if (w_sel_cyc)  w_rd_data = r_cycles;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_d_in   <= '0;
            r_leds   <= '0;
            r_cycles <= '0;
        end else begin
            r_d_in <= w_rd_data;
            if (w_en && w_sel_led) r_leds <= D_out[7:0];
            r_cycles <= (w_en && w_sel_cyc) ? '0 : r_cycles + 16'd1;
        end
    end

`ifdef RJ32_DBUS_UART_EN
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]       r_fifo [0:(1 << PTR_W) - 1];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             w_sel_udata, w_push, w_pop, w_full, w_accept, w_drop;
    logic             w_fifo_valid, w_tx_ready_c, w_tx_idle_c;

    assign w_sel_udata  = (A_data == ADDR_UART_DATA);
    assign w_push       = w_en && w_sel_udata;
    assign w_fifo_valid = (r_count != '0);
    assign w_pop        = w_fifo_valid && w_tx_ready_c;
    assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_accept     = w_push && (!w_full || w_pop);
    assign w_drop       = w_push && !w_accept;

    assign w_stat_idle = !w_fifo_valid && w_tx_idle_c;
    assign w_stat_full = w_full;
    assign w_stat_ovf  = r_overflow;

    always_ff @(posedge clock) begin
        if (w_accept) r_fifo[r_wr_ptr] <= D_out[7:0];
    end

    // A drop in the same cycle as a status read keeps overflow set
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop)          r_overflow <= 1'b1;
            else if (w_sel_stat) r_overflow <= 1'b0;
        end
    end

    rj32_uart_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_uart_tx (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_valid   (w_fifo_valid),
        .i_data    (r_fifo[r_rd_ptr]),
        .o_ready_c (w_tx_ready_c),
        .o_idle_c  (w_tx_idle_c),
        .o_tx      (tx)
    );
`else
    assign w_stat_idle = 1'b1;
    assign w_stat_full = 1'b0;
    assign w_stat_ovf  = 1'b0;
    assign tx          = 1'b1;
`endif

endmodule
